// File: rtl/bist_response_analyzer_pkg.sv
// Shared types and default constants for the BIST response analyzer.
// Holds the FSM state encoding and the MISR polynomial/seed defaults.
package bist_pkg;

    localparam int          DEF_DATA_W = 7;
    localparam int          DEF_MISR_W = 16;
    localparam int          DEF_CNT_W  = 16;
    localparam logic [15:0] DEF_POLY   = 16'h1021;
    localparam logic [15:0] DEF_SEED   = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_CAPTURE,
        ST_COMPARE,
        ST_DONE
    } bist_state_e;

    function automatic logic is_busy(input bist_state_e s);
        return (s == ST_SEED) || (s == ST_CAPTURE) || (s == ST_COMPARE);
    endfunction

endpackage

// File: rtl/bist_response_analyzer_if.sv
// Control, response and status bundle between the self-test wrapper and the analyzer.
// The wrapper side is the master; the analyzer is the slave.
interface bist_response_analyzer_if
    import bist_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MISR_W = DEF_MISR_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  num_vectors;
    logic [MISR_W-1:0] exp_sig;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;
    logic [CNT_W-1:0]  vec_count;

    modport master (
        output start, abort, num_vectors, exp_sig, resp_valid, resp_data,
        input  busy, done, pass, signature, vec_count
    );

    modport slave (
        input  start, abort, num_vectors, exp_sig, resp_valid, resp_data,
        output busy, done, pass, signature, vec_count
    );

endinterface

// File: rtl/bist_response_analyzer_misr_compactor.sv
// Multiple-input signature register: shift-left with polynomial feedback on MSB,
// response word XORed into the low bits. load has priority over en.
module misr_compactor
    import bist_pkg::*;
#(
    parameter int                DATA_W = DEF_DATA_W,
    parameter int                MISR_W = DEF_MISR_W,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEF_POLY),
    parameter logic [MISR_W-1:0] SEED   = MISR_W'(DEF_SEED)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [MISR_W-1:0] seed,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;
    logic [MISR_W-1:0] feedback;

    always_comb begin
        feedback = sig_q[MISR_W-1] ? POLY : '0;
        sig_d    = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (en) begin
            sig_d = {sig_q[MISR_W-2:0], 1'b0} ^ feedback ^ MISR_W'(din);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// Compacts DUT responses into a MISR signature over a programmed vector count,
// then compares against the expected signature and reports pass/fail.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_IDLE    | waiting for start
//  ST_SEED    | MISR loaded with SEED
//  ST_CAPTURE | folding valid responses, counting vectors
//  ST_COMPARE | signature final; compare registers pass on this edge
//  ST_DONE    | result held until next start or abort
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int                DATA_W = DEF_DATA_W,
    parameter int                MISR_W = DEF_MISR_W,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEF_POLY),
    parameter logic [MISR_W-1:0] SEED   = MISR_W'(DEF_SEED),
    parameter int                CNT_W  = DEF_CNT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    bist_response_analyzer_if.slave  bus
);

    bist_state_e       state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [MISR_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0]  vec_count_q, vec_count_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  vec_count_inc;
    logic              misr_load;
    logic              misr_en;
    logic [MISR_W-1:0] sig;

    assign vec_count_inc = vec_count_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        exp_d       = exp_q;
        vec_count_d = vec_count_q;
        done_d      = done_q;
        pass_d      = pass_q;
        misr_load   = 1'b0;
        misr_en     = 1'b0;

        // abort overrides everything, including a simultaneous start
        if (bus.abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        num_d       = bus.num_vectors;
                        exp_d       = bus.exp_sig;
                        vec_count_d = '0;
                        done_d      = 1'b0;
                        pass_d      = 1'b0;
                        state_d     = ST_SEED;
                    end
                end
                ST_SEED: begin
                    misr_load = 1'b1;
                    state_d   = (num_q == '0) ? ST_COMPARE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (bus.resp_valid) begin
                        misr_en     = 1'b1;
                        vec_count_d = vec_count_inc;
                        if (vec_count_inc == num_q) begin
                            state_d = ST_COMPARE;
                        end
                    end
                end
                ST_COMPARE: begin
                    pass_d  = (sig == exp_q);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = is_busy(state_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            exp_q       <= '0;
            vec_count_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            exp_q       <= exp_d;
            vec_count_q <= vec_count_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
        end
    end

    misr_compactor #(
        .DATA_W (DATA_W),
        .MISR_W (MISR_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clock (clock),
        .reset (reset),
        .load  (misr_load),
        .seed  (SEED),
        .en    (misr_en),
        .din   (bus.resp_data),
        .sig   (sig)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = sig;
    assign bus.vec_count = vec_count_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Randomized bench for bist_response_analyzer against a queue-based signature model.
module tb_bist_response_analyzer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    logic [6:0]  vecq[$];
    logic [15:0] exp_model;

    bist_response_analyzer_if #(.DATA_W(7), .MISR_W(16), .CNT_W(16)) bus();

    bist_response_analyzer dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Signature of the first n queued responses, as integer arithmetic on the polynomial rule
    function automatic logic [15:0] model_sig(input int n);
        int s = 'hFFFF;
        for (int i = 0; i < n; i++) begin
            s = ((s * 2) % 65536) ^ ((s >= 32768) ? 'h1021 : 0) ^ int'(vecq[i]);
        end
        return 16'(s);
    endfunction

    task automatic fill_random(input int n);
        vecq.delete();
        for (int i = 0; i < n; i++) vecq.push_back(7'($urandom_range(127)));
    endtask

    task automatic do_start(input int nv, input logic [15:0] es);
        bus.start       = 1'b1;
        bus.num_vectors = 16'(nv);
        bus.exp_sig     = es;
        @(negedge clk);
        bus.start       = 1'b0;
        @(negedge clk);
    endtask

    task automatic feed(input int n, input int bp, input int pulse_at, input int abort_at);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                bus.resp_valid = 1'b0;
                bus.abort      = 1'b1;
                @(negedge clk);
                bus.abort      = 1'b0;
                return;
            end
            while (int'($urandom_range(99)) < bp) begin
                bus.resp_valid = 1'b0;
                @(negedge clk);
            end
            bus.resp_valid = 1'b1;
            bus.resp_data  = vecq[i];
            if (i == pulse_at) begin
                bus.start       = 1'b1;
                bus.num_vectors = 16'd3;
                bus.exp_sig     = 16'h1234;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.resp_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
    endtask

    initial begin
        int idx;
        int b;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.num_vectors = '0;
        bus.exp_sig     = '0;
        bus.resp_valid  = 1'b0;
        bus.resp_data   = '0;
        repeat (2) @(negedge clk);

        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_pass", 32'(bus.pass), 0);
        chk("rst_sig",  32'(bus.signature), 32'hFFFF);
        chk("rst_cnt",  32'(bus.vec_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // zero vectors: signature stays at seed
        vecq.delete();
        do_start(0, 16'hFFFF);
        wait_done("t1");
        chk("t1_pass", 32'(bus.pass), 1);
        chk("t1_sig",  32'(bus.signature), 32'hFFFF);
        chk("t1_cnt",  32'(bus.vec_count), 0);
        chk("t1_busy", 32'(bus.busy), 0);

        vecq = {7'h00};
        do_start(1, 16'hEFDF);
        feed(1, 0, -1, -1);
        wait_done("t2a");
        chk("t2a_sig",  32'(bus.signature), 32'hEFDF);
        chk("t2a_pass", 32'(bus.pass), 1);
        chk("t2a_cnt",  32'(bus.vec_count), 1);
        do_start(1, 16'hEFDE);
        feed(1, 0, -1, -1);
        wait_done("t2b");
        chk("t2b_pass", 32'(bus.pass), 0);
        chk("t2b_sig",  32'(bus.signature), 32'hEFDF);

        vecq = {7'h01};
        do_start(1, 16'hEFDE);
        bus.resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        feed(1, 0, -1, -1);
        wait_done("t3");
        chk("t3_sig",  32'(bus.signature), 32'hEFDE);
        chk("t3_cnt",  32'(bus.vec_count), 1);
        chk("t3_pass", 32'(bus.pass), 1);

        // responses presented while DONE must be ignored
        bus.resp_valid = 1'b1;
        bus.resp_data  = 7'h55;
        repeat (3) @(negedge clk);
        bus.resp_valid = 1'b0;
        chk("done_hold_sig",  32'(bus.signature), 32'hEFDE);
        chk("done_hold_cnt",  32'(bus.vec_count), 1);
        chk("done_hold_done", 32'(bus.done), 1);

        fill_random(5000);
        exp_model = model_sig(5000);
        do_start(5000, exp_model);
        feed(5000, 20, -1, -1);
        wait_done("t4a");
        chk("t4a_pass", 32'(bus.pass), 1);
        chk("t4a_cnt",  32'(bus.vec_count), 5000);
        chk("t4a_sig",  32'(bus.signature), 32'(exp_model));

        idx = int'($urandom_range(4999));
        b   = int'($urandom_range(6));
        vecq[idx] = vecq[idx] ^ (7'd1 << b);
        do_start(5000, exp_model);
        feed(5000, 20, -1, -1);
        wait_done("t4b");
        chk("t4b_pass", 32'(bus.pass), 0);
        chk("t4b_sig",  32'(bus.signature), 32'(model_sig(5000)));

        // start pulsed mid-capture with different parameters
        fill_random(30);
        exp_model = model_sig(30);
        do_start(30, exp_model);
        feed(30, 10, 7, -1);
        wait_done("t5a");
        chk("t5a_pass", 32'(bus.pass), 1);
        chk("t5a_cnt",  32'(bus.vec_count), 30);
        chk("t5a_sig",  32'(bus.signature), 32'(exp_model));

        do_start(30, exp_model);
        feed(30, 10, -1, 10);
        chk("t5b_busy", 32'(bus.busy), 0);
        chk("t5b_done", 32'(bus.done), 0);
        chk("t5b_pass", 32'(bus.pass), 0);
        chk("t5b_cnt",  32'(bus.vec_count), 10);
        chk("t5b_sig",  32'(bus.signature), 32'(model_sig(10)));
        @(negedge clk);
        chk("t5b_idle", 32'(bus.busy), 0);

        // abort and start together from DONE: abort wins
        do_start(0, 16'hFFFF);
        wait_done("t5c");
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("t5c_busy", 32'(bus.busy), 0);
        chk("t5c_done", 32'(bus.done), 0);

        fill_random(20);
        exp_model = model_sig(20);
        do_start(20, exp_model);
        feed(5, 0, -1, -1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_done", 32'(bus.done), 0);
        chk("t6_pass", 32'(bus.pass), 0);
        chk("t6_sig",  32'(bus.signature), 32'hFFFF);
        chk("t6_cnt",  32'(bus.vec_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(20, exp_model);
        feed(20, 15, -1, -1);
        wait_done("t6r");
        chk("t6r_pass", 32'(bus.pass), 1);
        chk("t6r_sig",  32'(bus.signature), 32'(exp_model));
        chk("t6r_cnt",  32'(bus.vec_count), 20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
